// File: rtl/memory_block.sv
// memory_block: two ring buffers (A and B) of DATA_W-bit words kept in one
// shared single-port synchronous RAM. Each channel has a push port, a pop
// port and read-transaction controls (open / commit / rollback). A fixed
// priority arbiter (pushA > pushB > popA > popB) serialises the four
// requesters onto the RAM bus.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   pushX_request/data/done     push strobe, word to push, completion pulse
//   popX_request/data/done      pop strobe, popped word, completion pulse
//   ctlX_open/commit/rollback   read-transaction control
//   ctlX_empty/full/used        ring status (used counts uncommitted reads)
//   mem_addr/wdata/wren/rdata   RAM bus; read data valid RD_LAT cycles later
module memory_block #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int A_BASE = 0,
  parameter int A_SIZE = 128,
  parameter int B_BASE = 128,
  parameter int B_SIZE = 128,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pushA_request,
  input  logic [DATA_W-1:0] pushA_data,
  output logic              pushA_done,
  input  logic              pushB_request,
  input  logic [DATA_W-1:0] pushB_data,
  output logic              pushB_done,
  input  logic              popA_request,
  output logic [DATA_W-1:0] popA_data,
  output logic              popA_done,
  input  logic              popB_request,
  output logic [DATA_W-1:0] popB_data,
  output logic              popB_done,
  input  logic              ctlA_open,
  input  logic              ctlA_commit,
  input  logic              ctlA_rollback,
  input  logic              ctlB_open,
  input  logic              ctlB_commit,
  input  logic              ctlB_rollback,
  output logic              ctlA_empty,
  output logic              ctlA_full,
  output logic [ADDR_W:0]   ctlA_used,
  output logic              ctlB_empty,
  output logic              ctlB_full,
  output logic [ADDR_W:0]   ctlB_used,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT} state_t;

  state_t state, state_n;

  // Requester index: 0 pushA, 1 pushB, 2 popA, 3 popB (bit 0 = channel).
  logic [3:0]        req, pend, eff, grant_oh, done_q;
  logic [1:0]        grant, srv;
  logic              grant_valid;
  logic [3:0]        lat_cnt;
  logic [DATA_W-1:0] push_in [2];
  logic [DATA_W-1:0] push_q [2];
  logic [DATA_W-1:0] pop_q [2];
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] rd_addr_q;

  // Per-channel ring state. avail counts readable words; used also counts
  // words popped inside an open transaction, so used == avail outside one.
  logic [ADDR_W-1:0] wr_ptr [2], rd_ptr [2], snap [2];
  logic [ADDR_W-1:0] wr_n [2], rd_n [2], snap_n [2];
  logic [ADDR_W:0]   used [2], avail [2], used_n [2], avail_n [2], avail_mid [2];
  logic              act [2], act_n [2];
  logic              full [2], empty [2], push_inc [2], pop_issue [2], pop_none [2];
  logic              c_open [2], c_commit [2], c_rollback [2];

  function automatic logic [ADDR_W:0] size_of(input int c);
    return (c == 0) ? (ADDR_W+1)'(A_SIZE) : (ADDR_W+1)'(B_SIZE);
  endfunction

  function automatic logic [ADDR_W-1:0] base_of(input logic c);
    return c ? ADDR_W'(B_BASE) : ADDR_W'(A_BASE);
  endfunction

  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] p,
                                                 input logic [ADDR_W:0]   size);
    return ({1'b0, p} == size - 1'b1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    req           = {popB_request, popA_request, pushB_request, pushA_request};
    push_in[0]    = pushA_data;
    push_in[1]    = pushB_data;
    c_open[0]     = ctlA_open;
    c_open[1]     = ctlB_open;
    c_commit[0]   = ctlA_commit;
    c_commit[1]   = ctlB_commit;
    c_rollback[0] = ctlA_rollback;
    c_rollback[1] = ctlB_rollback;
  end

  // A fresh strobe is served in the same cycle it arrives, so the pending
  // flag only matters for requests that had to wait behind another one.
  always_comb begin
    eff         = pend | req;
    grant_valid = |eff;
    grant       = 2'd3;
    if (eff[0])      grant = 2'd0;
    else if (eff[1]) grant = 2'd1;
    else if (eff[2]) grant = 2'd2;
    grant_oh = '0;
    if (state == IDLE && grant_valid) grant_oh[grant] = 1'b1;
  end

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      full[c]      = (used[c] == size_of(c));
      empty[c]     = (avail[c] == '0);
      push_inc[c]  = (state == WRITE) && (srv == 2'(c)) && !full[c];
      pop_issue[c] = grant_oh[2+c] && !empty[c];
      pop_none[c]  = grant_oh[2+c] && empty[c];
    end
  end

  // Ring bookkeeping. The read pointer moves when the RAM read is issued so
  // that a rollback during the read latency restores a clean snapshot.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      wr_n[c]      = push_inc[c] ? wrap_inc(wr_ptr[c], size_of(c)) : wr_ptr[c];
      rd_n[c]      = pop_issue[c] ? wrap_inc(rd_ptr[c], size_of(c)) : rd_ptr[c];
      avail_mid[c] = avail[c] + (ADDR_W+1)'(push_inc[c]) - (ADDR_W+1)'(pop_issue[c]);
      avail_n[c]   = avail_mid[c];
      used_n[c]    = used[c] + (ADDR_W+1)'(push_inc[c])
                     - (act[c] ? '0 : (ADDR_W+1)'(pop_issue[c]));
      snap_n[c]    = snap[c];
      act_n[c]     = act[c];
      if (c_rollback[c] && act[c]) begin
        rd_n[c]    = snap[c];
        used_n[c]  = used[c] + (ADDR_W+1)'(push_inc[c]);
        avail_n[c] = used_n[c];
        act_n[c]   = 1'b0;
      end else if (c_commit[c] && act[c]) begin
        used_n[c]  = avail_mid[c];
        act_n[c]   = 1'b0;
      end else if (c_open[c]) begin
        // Re-opening commits the previous transaction implicitly.
        used_n[c]  = avail_mid[c];
        snap_n[c]  = rd_n[c];
        act_n[c]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          if (!grant[1])           state_n = WRITE;
          else if (!empty[grant[0]]) state_n = READ_WAIT;
        end
      end
      WRITE:     state_n = IDLE;
      READ_WAIT: if (lat_cnt == 4'(RD_LAT)) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    case (state)
      WRITE: begin
        mem_addr  = base_of(srv[0]) + wr_ptr[srv[0]];
        mem_wdata = wdata_q;
        mem_wren  = !full[srv[0]];
      end
      READ_WAIT: mem_addr = rd_addr_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= '0;
      srv       <= '0;
      done_q    <= '0;
      lat_cnt   <= '0;
      wdata_q   <= '0;
      rd_addr_q <= '0;
      for (int c = 0; c < 2; c++) begin
        push_q[c] <= '0;
        pop_q[c]  <= '0;
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        snap[c]   <= '0;
        used[c]   <= '0;
        avail[c]  <= '0;
        act[c]    <= 1'b0;
      end
    end else begin
      pend <= (pend | req) & ~grant_oh;
      for (int c = 0; c < 2; c++) begin
        if (req[c] && !pend[c]) push_q[c] <= push_in[c];
        wr_ptr[c] <= wr_n[c];
        rd_ptr[c] <= rd_n[c];
        snap[c]   <= snap_n[c];
        used[c]   <= used_n[c];
        avail[c]  <= avail_n[c];
        act[c]    <= act_n[c];
      end
      if (grant_oh != '0) begin
        srv       <= grant;
        wdata_q   <= pend[grant] ? push_q[grant[0]] : push_in[grant[0]];
        rd_addr_q <= base_of(grant[0]) + rd_ptr[grant[0]];
      end
      lat_cnt <= (state == READ_WAIT) ? lat_cnt + 4'd1 : 4'd0;
      done_q  <= '0;
      if (state == WRITE) done_q[srv] <= 1'b1;
      if (state == READ_WAIT && lat_cnt == 4'(RD_LAT)) begin
        done_q[srv]   <= 1'b1;
        pop_q[srv[0]] <= mem_rdata;
      end
      for (int c = 0; c < 2; c++)
        if (pop_none[c]) done_q[2+c] <= 1'b1;
    end
  end

  assign pushA_done = done_q[0];
  assign pushB_done = done_q[1];
  assign popA_done  = done_q[2];
  assign popB_done  = done_q[3];
  assign popA_data  = pop_q[0];
  assign popB_data  = pop_q[1];
  assign ctlA_empty = empty[0];
  assign ctlB_empty = empty[1];
  assign ctlA_full  = full[0];
  assign ctlB_full  = full[1];
  assign ctlA_used  = used[0];
  assign ctlB_used  = used[1];

endmodule

// File: tb/tb_memory_block.sv
// tb_memory_block: directed, table-driven bench for memory_block with a
// behavioural two-cycle-latency RAM model attached to the RAM bus.
module tb_memory_block;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pushA_request = 0, pushB_request = 0, popA_request = 0, popB_request = 0;
  logic [15:0] pushA_data = 0, pushB_data = 0;
  logic        pushA_done, pushB_done, popA_done, popB_done;
  logic [15:0] popA_data, popB_data;
  logic        ctlA_open = 0, ctlA_commit = 0, ctlA_rollback = 0;
  logic        ctlB_open = 0, ctlB_commit = 0, ctlB_rollback = 0;
  logic        ctlA_empty, ctlA_full, ctlB_empty, ctlB_full;
  logic [8:0]  ctlA_used, ctlB_used;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_wren;

  int errors = 0;
  int checks = 0;

  memory_block dut (
    .clk(clk), .rst(rst),
    .pushA_request(pushA_request), .pushA_data(pushA_data), .pushA_done(pushA_done),
    .pushB_request(pushB_request), .pushB_data(pushB_data), .pushB_done(pushB_done),
    .popA_request(popA_request), .popA_data(popA_data), .popA_done(popA_done),
    .popB_request(popB_request), .popB_data(popB_data), .popB_done(popB_done),
    .ctlA_open(ctlA_open), .ctlA_commit(ctlA_commit), .ctlA_rollback(ctlA_rollback),
    .ctlB_open(ctlB_open), .ctlB_commit(ctlB_commit), .ctlB_rollback(ctlB_rollback),
    .ctlA_empty(ctlA_empty), .ctlA_full(ctlA_full), .ctlA_used(ctlA_used),
    .ctlB_empty(ctlB_empty), .ctlB_full(ctlB_full), .ctlB_used(ctlB_used),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: address registered, then output registered (two-cycle read).
  logic [15:0] ram [256];
  logic [7:0]  addr_q = 0;
  logic [15:0] rdata_q = 0;
  logic [7:0]  wlog_addr [1024];
  logic [15:0] wlog_data [1024];
  int          wr_count = 0;

  always @(posedge clk) begin
    if (mem_wren) begin
      ram[mem_addr] <= mem_wdata;
      if (wr_count < 1024) begin
        wlog_addr[wr_count] <= mem_addr;
        wlog_data[wr_count] <= mem_wdata;
      end
      wr_count <= wr_count + 1;
    end
    addr_q  <= mem_addr;
    rdata_q <= ram[addr_q];
  end
  assign mem_rdata = rdata_q;

  typedef struct {
    int          op;        // 0 push, 1 pop, 2 reset
    int          ch;        // 0 = A, 1 = B
    logic [15:0] din;
    logic [15:0] exp_data;  // checked after pops and resets
    int          exp_used;
    logic        exp_empty;
    int          exp_lat;   // <= 0: only arrival of done is required
    int          exp_writes;
  } vec_t;

  vec_t vecs [10];

  function automatic logic done_of(input int op, input int ch);
    if (op == 0) return (ch == 0) ? pushA_done : pushB_done;
    return (ch == 0) ? popA_done : popB_done;
  endfunction

  function automatic int used_of(input int ch);
    return (ch == 0) ? int'(ctlA_used) : int'(ctlB_used);
  endfunction

  function automatic logic empty_of(input int ch);
    return (ch == 0) ? ctlA_empty : ctlB_empty;
  endfunction

  function automatic logic [15:0] data_of(input int ch);
    return (ch == 0) ? popA_data : popB_data;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Strobe one request at the current falling edge and wait (bounded) for
  // its done pulse; lat is the number of falling edges until done is seen.
  task automatic applyStimulus(input int op, input int ch, input logic [15:0] din,
                               output int lat);
    if (op == 0 && ch == 0) begin pushA_request = 1; pushA_data = din; end
    if (op == 0 && ch == 1) begin pushB_request = 1; pushB_data = din; end
    if (op == 1 && ch == 0) popA_request = 1;
    if (op == 1 && ch == 1) popB_request = 1;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      pushA_request = 0; pushB_request = 0; popA_request = 0; popB_request = 0;
      if (done_of(op, ch)) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat == 0) begin
      errors++;
      $display("[TB] FAIL done_timeout op=%0d ch=%0d: got no done expected done", op, ch);
    end
  endtask

  // Pulse a channel-A control combination for one clock.
  task automatic ctlA_pulse(input logic o, input logic c, input logic r);
    ctlA_open = o; ctlA_commit = c; ctlA_rollback = r;
    @(negedge clk);
    ctlA_open = 0; ctlA_commit = 0; ctlA_rollback = 0;
  endtask

  task automatic pop_check(input string name, input logic [15:0] exp_d, input int exp_u);
    int lat;
    applyStimulus(1, 0, 16'h0, lat);
    checkOutput({name, " data"}, 32'(popA_data), 32'(exp_d));
    checkOutput({name, " used"}, 32'(ctlA_used), 32'(exp_u));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, lat_a, lat_b, w0, dones;

    vecs[0] = '{0, 0, 16'hEF01, 16'h0000, 2, 1'b0, 2, 1};
    vecs[1] = '{0, 0, 16'h2345, 16'h0000, 3, 1'b0, 2, 1};
    vecs[2] = '{0, 1, 16'h6789, 16'h0000, 2, 1'b0, 2, 1};
    vecs[3] = '{1, 0, 16'h0000, 16'hABCD, 2, 1'b0, 4, 0};
    vecs[4] = '{1, 1, 16'h0000, 16'h2222, 1, 1'b0, 4, 0};
    vecs[5] = '{2, 0, 16'h0000, 16'h0000, 0, 1'b1, 0, 0};
    vecs[6] = '{0, 0, 16'h1111, 16'h0000, 1, 1'b0, 2, 1};
    vecs[7] = '{1, 0, 16'h0000, 16'h1111, 0, 1'b1, 4, 0};
    vecs[8] = '{1, 0, 16'h0000, 16'h1111, 0, 1'b1, 0, 0};
    vecs[9] = '{1, 1, 16'h0000, 16'h0000, 0, 1'b1, 0, 0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset state");
    checkOutput("rst emptyA", 32'(ctlA_empty), 32'd1);
    checkOutput("rst emptyB", 32'(ctlB_empty), 32'd1);
    checkOutput("rst fullA", 32'(ctlA_full), 32'd0);
    checkOutput("rst usedA", 32'(ctlA_used), 32'd0);
    checkOutput("rst usedB", 32'(ctlB_used), 32'd0);
    checkOutput("rst popA_data", 32'(popA_data), 32'd0);
    checkOutput("rst wren", 32'(mem_wren), 32'd0);
    checkOutput("rst addr", 32'(mem_addr), 32'd0);
    checkOutput("rst dones", 32'({pushA_done, pushB_done, popA_done, popB_done}), 32'd0);

    $display("[TB] simultaneous pushes");
    w0 = wr_count;
    pushA_request = 1; pushA_data = 16'hABCD;
    pushB_request = 1; pushB_data = 16'h2222;
    lat_a = 0; lat_b = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      pushA_request = 0; pushB_request = 0;
      if (pushA_done) lat_a = k;
      if (pushB_done) lat_b = k;
      if (lat_a != 0 && lat_b != 0) break;
    end
    checkOutput("sim latA", 32'(lat_a), 32'd2);
    checkOutput("sim latB", 32'(lat_b), 32'd4);
    checkOutput("sim writes", 32'(wr_count - w0), 32'd2);
    checkOutput("sim addr0", 32'(wlog_addr[w0]), 32'd0);
    checkOutput("sim data0", 32'(wlog_data[w0]), 32'hABCD);
    checkOutput("sim addr1", 32'(wlog_addr[w0+1]), 32'd128);
    checkOutput("sim data1", 32'(wlog_data[w0+1]), 32'h2222);
    checkOutput("sim usedA", 32'(ctlA_used), 32'd1);
    checkOutput("sim usedB", 32'(ctlB_used), 32'd1);

    $display("[TB] vector table");
    for (int i = 0; i < 10; i++) begin
      w0 = wr_count;
      lat = 0;
      if (vecs[i].op == 2) do_reset();
      else applyStimulus(vecs[i].op, vecs[i].ch, vecs[i].din, lat);
      if (vecs[i].op != 0)
        checkOutput($sformatf("vec%0d data", i), 32'(data_of(vecs[i].ch)), 32'(vecs[i].exp_data));
      checkOutput($sformatf("vec%0d used", i), 32'(used_of(vecs[i].ch)), 32'(vecs[i].exp_used));
      checkOutput($sformatf("vec%0d empty", i), 32'(empty_of(vecs[i].ch)), 32'(vecs[i].exp_empty));
      if (vecs[i].exp_lat > 0)
        checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      if (vecs[i].op != 2)
        checkOutput($sformatf("vec%0d writes", i), 32'(wr_count - w0), 32'(vecs[i].exp_writes));
    end

    $display("[TB] fill ring A");
    do_reset();
    for (int i = 0; i < 128; i++) begin
      applyStimulus(0, 0, 16'(16'h5000 + i), lat);
      if (i == 126) checkOutput("fill full@127", 32'(ctlA_full), 32'd0);
    end
    checkOutput("fill full", 32'(ctlA_full), 32'd1);
    checkOutput("fill used", 32'(ctlA_used), 32'd128);
    w0 = wr_count;
    applyStimulus(0, 0, 16'hDEAD, lat);
    checkOutput("overflow writes", 32'(wr_count - w0), 32'd0);
    checkOutput("overflow used", 32'(ctlA_used), 32'd128);
    pop_check("fill pop", 16'h5000, 127);
    checkOutput("fill full after pop", 32'(ctlA_full), 32'd0);
    w0 = wr_count;
    applyStimulus(0, 0, 16'hBEEF, lat);
    checkOutput("wrap addr", 32'(wlog_addr[w0]), 32'd0);
    checkOutput("wrap data", 32'(wlog_data[w0]), 32'hBEEF);
    checkOutput("wrap full", 32'(ctlA_full), 32'd1);

    $display("[TB] read transactions");
    do_reset();
    applyStimulus(0, 0, 16'hA001, lat);
    applyStimulus(0, 0, 16'hA002, lat);
    applyStimulus(0, 0, 16'hA003, lat);
    ctlA_pulse(1, 0, 0);
    pop_check("txn pop1", 16'hA001, 3);
    pop_check("txn pop2", 16'hA002, 3);
    ctlA_pulse(0, 0, 1);
    checkOutput("rollback used", 32'(ctlA_used), 32'd3);
    checkOutput("rollback empty", 32'(ctlA_empty), 32'd0);
    ctlA_pulse(1, 0, 0);
    pop_check("replay pop", 16'hA001, 3);
    ctlA_pulse(0, 0, 1);
    ctlA_pulse(1, 0, 0);
    pop_check("commit pop1", 16'hA001, 3);
    pop_check("commit pop2", 16'hA002, 3);
    ctlA_pulse(0, 1, 0);
    checkOutput("commit used", 32'(ctlA_used), 32'd1);
    ctlA_pulse(1, 0, 0);
    pop_check("prio pop", 16'hA003, 1);
    checkOutput("prio empty before", 32'(ctlA_empty), 32'd1);
    ctlA_pulse(0, 1, 1);
    checkOutput("prio used", 32'(ctlA_used), 32'd1);
    checkOutput("prio empty", 32'(ctlA_empty), 32'd0);
    pop_check("prio repop", 16'hA003, 0);
    checkOutput("final empty", 32'(ctlA_empty), 32'd1);

    $display("[TB] reset during pop");
    do_reset();
    applyStimulus(0, 0, 16'h7777, lat);
    dones = 0;
    popA_request = 1;
    @(negedge clk);
    popA_request = 0;
    if (popA_done) dones++;
    @(negedge clk);
    if (popA_done) dones++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if (popA_done) dones++;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (popA_done) dones++;
    end
    checkOutput("abort dones", 32'(dones), 32'd0);
    checkOutput("abort empty", 32'(ctlA_empty), 32'd1);
    checkOutput("abort used", 32'(ctlA_used), 32'd0);
    checkOutput("abort data", 32'(popA_data), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_block.md
Name: memory_block

Overview:
- Dual-channel ring-buffer controller (channels A and B) that stores 16-bit words in one shared single-port synchronous RAM.
- Each channel has a push port, a pop port and a read-transaction control port (open/commit/rollback).
- The block arbitrates all four requesters onto the single RAM bus.
- It sits between the protocol engines (Mil-1553 and SPI sides) and the RAM wrapper.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 8, RAM address width.
- A_BASE, 0, first RAM address of ring A.
- A_SIZE, 128, word capacity of ring A.
- B_BASE, 128, first RAM address of ring B.
- B_SIZE, 128, word capacity of ring B.
- RD_LAT, 2, RAM read latency in cycles (address registered, output registered).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- pushA_request / pushB_request  in  1  one-cycle push strobe.
- pushA_data / pushB_data  in  16  word to push, sampled with the request.
- pushA_done / pushB_done  out  1  one-cycle completion pulse.
- popA_request / popB_request  in  1  one-cycle pop strobe.
- popA_data / popB_data  out  16  popped word.
- popA_done / popB_done  out  1  one-cycle completion pulse.
- ctlA_open/commit/rollback, ctlB_open/commit/rollback  in  1 each  read-transaction control.
- ctlA_empty / ctlB_empty  out  1  no readable word.
- ctlA_full / ctlB_full  out  1  ring full.
- ctlA_used / ctlB_used  out  ADDR_W+1  words stored (includes uncommitted-read words).
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  16  RAM write data.
- mem_wren  out  1  RAM write enable.
- mem_rdata  in  16  RAM read data, valid RD_LAT cycles after address.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - all pointers and counts 0; empty=1, full=0, used=0;
  - all done outputs 0; pop data 0; mem_wren 0, mem_addr 0; pending flags cleared.
- Request capture:
  - each request strobe sets a per-port pending flag, and push data is latched in the same cycle;
  - simultaneous strobes on different ports are never lost;
  - a repeat strobe on a port already pending is ignored.
- Arbiter states: IDLE, WRITE, READ_WAIT.
  - In IDLE, the highest-priority pending request is served, in this order: pushA, pushB, popA, popB.
- Push:
  - WRITE takes one cycle: mem_addr = base + wr_ptr, mem_wren = 1.
  - done pulses the next cycle; wr_ptr advances with wrap at SIZE; used increments.
  - Push when full: no RAM write, pointer unchanged, done still pulses.
- Pop:
  - address = base + rd_ptr; wait RD_LAT cycles, then capture mem_rdata into pop data and pulse done.
  - pop data holds until the next successful pop.
  - rd_ptr advances with wrap.
  - Pop when empty: no RAM access, done pulses next cycle, data unchanged.
- Latency from request strobe to done: push 2 cycles, pop 2+RD_LAT cycles, measured when uncontended. Each served request adds this latency for lower-priority ports.
- Read transactions:
  - open saves rd_ptr as the snapshot and marks the transaction active.
  - Pops inside a transaction advance rd_ptr, but their slots stay occupied: used and full are unchanged.
  - commit frees the slots from snapshot to rd_ptr and ends the transaction.
  - rollback restores rd_ptr to the snapshot and ends the transaction.
  - With no transaction open, pops free slots immediately.
  - commit or rollback with no transaction open: no effect.
  - open while a transaction is already active: re-snapshots (implicit commit).
  - Control signals act in the cycle they are high. If more than one is high, priority is rollback > commit > open.
- empty means there are no words between rd_ptr and wr_ptr. full means used == SIZE.
- Channels are fully independent except for sharing the RAM.
- Reset mid-operation aborts any RAM access and clears all state; no done pulse is issued for the aborted request.

Test Plan:
- Reset, then pushA 0xABCD and pushB 0x2222 strobed in the same cycle -> A is written first at address A_BASE, B at B_BASE; both done pulses occur; usedA = usedB = 1.
- Continue with pushA 0xEF01 and 0x2345, then pushB 0x6789, popA, popB -> popA_data = 0xABCD, popB_data = 0x2222; usedA = 2, usedB = 1.
- Pop from empty A -> done pulses, no RAM access, data unchanged, empty stays 1.
- Push A_SIZE+1 words to A -> full = 1 after A_SIZE pushes; the extra push does not write RAM; pointers wrap to A_BASE.
- Push 3 words to A, open, pop 2, rollback, pop -> the final pop returns the first word again; used stays 3 throughout.
- Open, pop 2, commit -> used drops by 2.
- Assert rst during a pending pop -> no done pulse; empty = 1 after reset.
